// File: rtl/divider_pkg.sv
// Shared constants for the restoring divider: FSM state encodings and default width.
// DIVIDER_SIGNED_EN adds the FIX state used for two's complement sign correction.
package divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
`ifdef DIVIDER_SIGNED_EN
  localparam logic [1:0] FIX  = 2'd3;
`endif

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// subtract the divisor when it fits, and emit the matching quotient bit.
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] divisor_ext;

  assign rem_shift   = {rem_in[WIDTH-1:0], dvd_bit};
  assign divisor_ext = {1'b0, divisor};

  // A set top bit means the shifted value already exceeds any WIDTH-bit divisor.
  assign q_bit   = rem_in[WIDTH] | (rem_shift >= divisor_ext);
  assign rem_out = q_bit ? (rem_shift - divisor_ext) : rem_shift;

endmodule

// File: rtl/eight_bits_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIVIDER_SIGNED_EN for two's complement operands (adds one sign-fix cycle).
module eight_bits_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only on a rising edge where the FSM is IDLE
  // (busy=0); operands are captured on that edge. busy stays high through CALC
  // and DONE, done pulses for the single DONE cycle, and the result outputs
  // change only on entry to DONE and then hold until the next accepted start.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] dvd_r;   // dividend shifts out, quotient bits shift in
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
`ifdef DIVIDER_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
`endif

  assign dbg_state = state;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .dvd_bit (dvd_r[WIDTH-1]),
    .divisor (dsr_r),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      dvd_r       <= '0;
      dsr_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              cnt   <= CW'(WIDTH - 1);
              rem_r <= '0;
`ifdef DIVIDER_SIGNED_EN
              // Divide magnitudes; -MIN still fits as an unsigned WIDTH-bit value.
              dvd_r <= dividend[WIDTH-1] ? -dividend : dividend;
              dsr_r <= divisor[WIDTH-1]  ? -divisor  : divisor;
              neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r <= dividend[WIDTH-1];
`else
              dvd_r <= dividend;
              dsr_r <= divisor;
`endif
            end
          end
        end
        CALC: begin
          rem_r <= step_rem;
          dvd_r <= {dvd_r[WIDTH-2:0], step_q};
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
`ifdef DIVIDER_SIGNED_EN
            state <= FIX;
`else
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= {dvd_r[WIDTH-2:0], step_q};
            remainder <= step_rem[WIDTH-1:0];
`endif
          end
        end
`ifdef DIVIDER_SIGNED_EN
        FIX: begin
          state     <= DONE;
          done      <= 1'b1;
          quotient  <= neg_q ? -dvd_r : dvd_r;
          remainder <= neg_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
        end
`endif
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eight_bits_divider.sv
// Self-checking bench for eight_bits_divider: scoreboard of expected results,
// one task per scenario. Honours DIVIDER_SIGNED_EN for the signed build.
module tb_eight_bits_divider;

  localparam int W = 8;
`ifdef DIVIDER_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // {dz, q, r}
  logic [2*W:0] exp_q[$];

  eight_bits_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    int sa;
    int sb;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef DIVIDER_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
    q = W'(sa / sb);
    r = W'(sa % sb);
`else
    sa = 0;
    sb = 0;
    q = a / b;
    r = a % b;
`endif
    return {1'b0, q, r};
  endfunction

  // ---------------- driver + scoreboard ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b required 0 after 50 cycles", busy);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    int want_lat;
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;
    logic [2*W:0] e;
    wait_idle();
    prev_q = quotient;
    prev_r = remainder;
    want_lat = (b == '0) ? 1 : LAT;
    dividend = a;
    divisor = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 4) begin
        checks++;
        if (quotient !== prev_q || remainder !== prev_r || busy !== 1'b1 ||
            div_by_zero !== 1'b0 || dbg_state !== 2'd1) begin
          errors++;
          $display("FAIL %s mid-op: q=%h r=%h busy=%b dz=%b st=%0d required q=%h r=%h busy=1 dz=0 st=1",
                   name, quotient, remainder, busy, div_by_zero, dbg_state, prev_q, prev_r);
        end
      end
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat !== want_lat) begin
      errors++;
      $display("FAIL %s latency: done=%b after %0d cycles, required done=1 after %0d",
               name, done, lat, want_lat);
    end
    e = exp_q.pop_front();
    checks++;
    if ({div_by_zero, quotient, remainder} !== e) begin
      errors++;
      $display("FAIL %s result: dz=%b q=%h r=%h required dz=%b q=%h r=%h",
               name, div_by_zero, quotient, remainder, e[2*W], e[2*W-1:W], e[W-1:0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {div_by_zero, quotient, remainder} !== e) begin
      errors++;
      $display("FAIL %s after done: done=%b busy=%b q=%h r=%h required done=0 busy=0 q=%h r=%h",
               name, done, busy, quotient, remainder, e[2*W-1:W], e[W-1:0]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 ||
        div_by_zero !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b q=%h r=%h dz=%b st=%0d required all 0",
               busy, done, quotient, remainder, div_by_zero, dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op("200/7", 8'd200, 8'd7);
    run_op("255/1", 8'd255, 8'd1);
    run_op("5/9", 8'd5, 8'd9);
    run_op("0/3", 8'd0, 8'd3);
    run_op("200/200", 8'd200, 8'd200);
  endtask

  task automatic test_div_zero();
    run_op("13/0", 8'd13, 8'd0);
    run_op("dz_clear 9/2", 8'd9, 8'd2);
  endtask

  task automatic test_start_held();
    int dones = 0;
    logic [2*W:0] e;
    wait_idle();
    dividend = 8'd100;
    divisor = 8'd10;
    start = 1'b1;
    exp_q.push_back(model(8'd100, 8'd10));
    exp_q.push_back(model(8'd50, 8'd5));
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        dividend = 8'd50;
        divisor = 8'd5;
      end
      if (done) begin
        dones++;
        e = exp_q.pop_front();
        checks++;
        if (i !== LAT || {div_by_zero, quotient, remainder} !== e) begin
          errors++;
          $display("FAIL held first: cycle %0d q=%h r=%h required cycle %0d q=%h r=%h",
                   i, quotient, remainder, LAT, e[2*W-1:W], e[W-1:0]);
        end
      end
      if (i == LAT + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL held done-cycle start: busy=%b required 0", busy);
        end
      end
    end
    checks++;
    if (dones !== 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL held window: dones=%0d busy=%b required dones=1 busy=1", dones, busy);
    end
    start = 1'b0;
    begin
      int n = 0;
      while (!done && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || {div_by_zero, quotient, remainder} !== e) begin
      errors++;
      $display("FAIL held second: done=%b q=%h r=%h required done=1 q=%h r=%h",
               done, quotient, remainder, e[2*W-1:W], e[W-1:0]);
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    wait_idle();
    dividend = 8'd200;
    divisor = 8'd7;
    start = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 ||
        div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b q=%h r=%h dz=%b required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checks++;
    if (dones !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort no-done: dones=%0d busy=%b required 0 0", dones, busy);
    end
    run_op("post-abort 9/2", 8'd9, 8'd2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom_range(0, 255));
      b = (i % 5 == 4) ? '0 : W'($urandom_range(1, 255));
      run_op($sformatf("rand%0d", i), a, b);
    end
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    run_op("s -7/2", 8'hF9, 8'h02);
    run_op("s -128/-1", 8'h80, 8'hFF);
    run_op("s 7/-2", 8'h07, 8'hFE);
    run_op("s -13/0", 8'hF3, 8'h00);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_start_held();
    test_abort();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
